// File: rtl/rf_writeback_arbiter_if.sv
// Writeback bundle between the requesters, the arbiter and the register file write port.
// The requester side (master) drives the src_* lines and wb_hold; the arbiter (slave) drives ready and the RF port.
interface rf_writeback_arbiter_if #(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC*ADDR_W-1:0] src_reg;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_ready;
  logic                    wb_hold;
  logic                    RegWrite;
  logic [ADDR_W-1:0]       Write_register;
  logic [DATA_W-1:0]       Write_data;
  logic [2:0]              grant_id;
  logic [15:0]             wb_count;

  modport master (
    output src_valid, src_reg, src_data, wb_hold,
    input  src_ready, RegWrite, Write_register, Write_data, grant_id, wb_count
  );

  modport slave (
    input  src_valid, src_reg, src_data, wb_hold,
    output src_ready, RegWrite, Write_register, Write_data, grant_id, wb_count
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Round-robin share of the register file write port among N_SRC writeback requesters.
// Grant is combinational; the granted write reaches the RF port one cycle later.
module rf_writeback_arbiter #(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  rf_writeback_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(N_SRC);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_register_q, write_register_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [2:0]        grant_id_q, grant_id_d;
  logic [15:0]       wb_count_q, wb_count_d;

  logic              found;
  logic              hs;
  logic [PTR_W-1:0]  gnt;
  logic [PTR_W:0]    cand;
  logic [N_SRC-1:0]  src_ready_c;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  // Search upward from rr_ptr with wrap; one extra bit keeps the sum from overflowing before the wrap.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(N_SRC)) begin
        cand = cand - (PTR_W+1)'(N_SRC);
      end
      if (!found && bus.src_valid[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        gnt   = cand[PTR_W-1:0];
      end
    end
  end

  assign hs       = found & ~bus.wb_hold;
  assign sel_reg  = bus.src_reg[int'(gnt)*ADDR_W +: ADDR_W];
  assign sel_data = bus.src_data[int'(gnt)*DATA_W +: DATA_W];

  always_comb begin
    src_ready_c = '0;
    if (hs) begin
      src_ready_c[gnt] = 1'b1;
    end
  end

  // Register-0 writes still consume the grant and advance the pointer, but never pulse RegWrite.
  always_comb begin
    rr_ptr_d         = rr_ptr_q;
    reg_write_d      = 1'b0;
    write_register_d = write_register_q;
    write_data_d     = write_data_q;
    grant_id_d       = grant_id_q;
    if (hs) begin
      reg_write_d      = (sel_reg != '0);
      write_register_d = sel_reg;
      write_data_d     = sel_data;
      grant_id_d       = 3'(gnt);
      rr_ptr_d         = (gnt == PTR_W'(N_SRC - 1)) ? '0 : gnt + PTR_W'(1);
    end
    wb_count_d = wb_count_q + 16'(reg_write_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q         <= '0;
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      grant_id_q       <= '0;
      wb_count_q       <= '0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
      grant_id_q       <= grant_id_d;
      wb_count_q       <= wb_count_d;
    end
  end

  assign bus.src_ready      = src_ready_c;
  assign bus.RegWrite       = reg_write_q;
  assign bus.Write_register = write_register_q;
  assign bus.Write_data     = write_data_q;
  assign bus.grant_id       = grant_id_q;
  assign bus.wb_count       = wb_count_q;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: stimulus pushes expected ready vectors and RF writes
// into queues; a negedge monitor pops and compares them as the DUT presents them.
module tb_rf_writeback_arbiter;
  localparam int N = 3;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    logic [2:0]  g;
    logic [15:0] c;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  valid = '0;
  logic        hold = 1'b0;
  logic [4:0]  sreg [N];
  logic [31:0] sdat [N];

  logic [2:0]  rdy_q [$];
  wr_t         wr_q [$];
  logic [15:0] exp_cnt = '0;
  int          total = 0;
  int          bad = 0;

  rf_writeback_arbiter_if #(.N_SRC(N), .DATA_W(32), .ADDR_W(5)) bus ();

  rf_writeback_arbiter #(.N_SRC(N), .DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.src_valid = valid;
  assign bus.wb_hold   = hold;
  assign bus.src_reg   = {sreg[2], sreg[1], sreg[0]};
  assign bus.src_data  = {sdat[2], sdat[1], sdat[0]};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Monitor
  wr_t        mon_e;
  logic [2:0] mon_r;
  always @(negedge clk) begin
    if (rdy_q.size() > 0) begin
      mon_r = rdy_q.pop_front();
      total++;
      if (bus.src_ready !== mon_r) begin
        bad++;
        $display("FAIL src_ready: got %b want %b at %0t", bus.src_ready, mon_r, $time);
      end
    end
    if (bus.RegWrite !== 1'b0) begin
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: RegWrite=%b reg=%0d data=%h at %0t",
                 bus.RegWrite, bus.Write_register, bus.Write_data, $time);
      end else begin
        mon_e = wr_q.pop_front();
        if (bus.RegWrite !== 1'b1 || bus.Write_register !== mon_e.r || bus.Write_data !== mon_e.d ||
            bus.grant_id !== mon_e.g || bus.wb_count !== mon_e.c) begin
          bad++;
          $display("FAIL rf_write: got reg=%0d data=%h gid=%0d cnt=%0d want reg=%0d data=%h gid=%0d cnt=%0d at %0t",
                   bus.Write_register, bus.Write_data, bus.grant_id, bus.wb_count,
                   mon_e.r, mon_e.d, mon_e.g, mon_e.c, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic h, input logic [2:0] er);
    wr_t e;
    valid = v;
    hold  = h;
    rdy_q.push_back(er);
    for (int i = 0; i < N; i++) begin
      if (er[i] && sreg[i] != 5'd0) begin
        exp_cnt++;
        e.r = sreg[i];
        e.d = sdat[i];
        e.g = 3'(i);
        e.c = exp_cnt;
        wr_q.push_back(e);
      end
    end
  endtask

  task automatic cyc(input logic [2:0] v, input logic h, input logic [2:0] er);
    tick();
    drive(v, h, er);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_RegWrite"}, 32'(bus.RegWrite), 32'd0);
    check({tag, "_Write_register"}, 32'(bus.Write_register), 32'd0);
    check({tag, "_Write_data"}, bus.Write_data, 32'd0);
    check({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
    check({tag, "_wb_count"}, 32'(bus.wb_count), 32'd0);
  endtask

  // Asynchronous pulse placed between clock edges; pending expectations die with the state.
  task automatic pulse_reset(input string tag);
    #1 reset = 1'b1;
    #1 check_zero_outputs(tag);
    rdy_q.delete();
    wr_q.delete();
    exp_cnt = '0;
    #1 reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      sreg[i] = '0;
      sdat[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("por");
    check("por_src_ready", 32'(bus.src_ready), 32'd0);
    reset = 1'b0;

    // Single requester, first transaction.
    tick();
    sreg[0] = 5'd5;
    sdat[0] = 32'hDEADBEEF;
    drive(3'b001, 1'b0, 3'b001);
    cyc(3'b000, 1'b0, 3'b000);
    cyc(3'b000, 1'b0, 3'b000);
    pulse_reset("rst1");

    // All three valid: strict rotation from source 0.
    tick();
    sreg[0] = 5'd1;  sdat[0] = 32'hA0A0_0001;
    sreg[1] = 5'd2;  sdat[1] = 32'hB0B0_0002;
    sreg[2] = 5'd3;  sdat[2] = 32'hC0C0_0003;
    drive(3'b111, 1'b0, 3'b001);
    cyc(3'b111, 1'b0, 3'b010);
    cyc(3'b111, 1'b0, 3'b100);
    cyc(3'b111, 1'b0, 3'b001);
    cyc(3'b111, 1'b0, 3'b010);
    cyc(3'b111, 1'b0, 3'b100);
    cyc(3'b000, 1'b0, 3'b000);

    // Wrap-around: move rr_ptr to 1, then sources 0 and 2 compete.
    cyc(3'b001, 1'b0, 3'b001);
    cyc(3'b101, 1'b0, 3'b100);
    cyc(3'b101, 1'b0, 3'b001);
    cyc(3'b000, 1'b0, 3'b000);

    // Register-0 write from source 1 consumes the grant silently; next search starts at 2.
    tick();
    sreg[1] = 5'd0;
    sdat[1] = 32'h0000_1234;
    drive(3'b010, 1'b0, 3'b010);
    tick();
    sreg[1] = 5'd2;
    drive(3'b111, 1'b0, 3'b100);
    cyc(3'b000, 1'b0, 3'b000);

    // Hold for three cycles, then exactly one grant of source 1.
    cyc(3'b010, 1'b1, 3'b000);
    cyc(3'b010, 1'b1, 3'b000);
    cyc(3'b010, 1'b1, 3'b000);
    cyc(3'b010, 1'b0, 3'b010);
    cyc(3'b000, 1'b0, 3'b000);

    // Reset mid-stream while RegWrite is high; afterwards source 0 wins first.
    cyc(3'b111, 1'b0, 3'b100);
    cyc(3'b111, 1'b0, 3'b001);
    check("pre_reset_RegWrite", 32'(bus.RegWrite), 32'd1);
    pulse_reset("rst2");
    drive(3'b111, 1'b0, 3'b001);
    cyc(3'b111, 1'b0, 3'b010);
    cyc(3'b000, 1'b0, 3'b000);
    cyc(3'b000, 1'b0, 3'b000);
    cyc(3'b000, 1'b0, 3'b000);
    tick();

    check("writes_outstanding", 32'(wr_q.size()), 32'd0);
    check("ready_outstanding", 32'(rdy_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
Shares the register file's single write port among N_SRC writeback requesters, e.g. ALU result, load return and multiply/divide unit. Each requester presents a destination index and data under a valid/ready handshake. A round-robin arbiter grants at most one requester per cycle. The granted write is registered and driven onto the register file's RegWrite / Write_register / Write_data inputs one cycle later.

Parameters:
N_SRC, 3, number of writeback requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register index width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high
src_valid  input  N_SRC  bit i: requester i holds a pending write
src_reg  input  N_SRC*ADDR_W  slice i: destination register of requester i
src_data  input  N_SRC*DATA_W  slice i: write data of requester i
src_ready  output  N_SRC  bit i: requester i's write is accepted this cycle
wb_hold  input  1  blocks all grants this cycle
RegWrite  output  1  write enable to register file
Write_register  output  ADDR_W  write index to register file
Write_data  output  DATA_W  write data to register file
grant_id  output  3  index of the source whose write is on the port; valid when RegWrite=1
wb_count  output  16  count of completed non-zero-register writes, wraps

Behaviour:
- Reset (async, any cycle including mid-transfer): RegWrite=0, Write_register=0, Write_data=0, grant_id=0, wb_count=0, rr_ptr=0. Any handshake in the reset cycle is discarded.
- rr_ptr is log2(N_SRC) bits. It marks the highest-priority source.
- Arbitration is combinational. Search src_valid starting at rr_ptr, ascending, wrapping modulo N_SRC. The first set bit is the grant g.
- src_ready is one-hot at bit g only when a valid source exists and wb_hold=0. Otherwise src_ready=0.
- src_ready depends only on src_valid, rr_ptr and wb_hold. It never depends on src_reg or src_data.
- A handshake on source i is src_valid[i] & src_ready[i].
- Requesters hold valid, reg and data stable until their handshake.
- Handshake on g at edge t:
  - RegWrite <= (src_reg slice g != 0)
  - Write_register <= src_reg slice g
  - Write_data <= src_data slice g
  - grant_id <= g
  - rr_ptr <= (g+1) mod N_SRC
  - The write appears on the port in cycle t+1. Latency is exactly 1 cycle.
- No handshake (no valid or wb_hold=1): RegWrite <= 0. Write_register, Write_data and grant_id keep their last values. rr_ptr is unchanged.
- Writes to register 0 complete the handshake and advance rr_ptr. They produce no RegWrite pulse and do not increment wb_count.
- wb_count increments on every cycle with RegWrite=1. It wraps from 0xFFFF to 0.
- Throughput: one write per cycle. Back-to-back grants to different sources are allowed.
- A single source continuously valid with no competitor is granted every cycle.
- With all sources continuously valid, each source is granted once every N_SRC cycles.
- wb_hold asserted mid-stream: the grant is withheld that cycle and no state other than RegWrite changes. The next cycle with wb_hold=0 grants from the unchanged rr_ptr.
- Out-of-order arrival is not reordered. Same-cycle writes to the same register from two sources are serialized in round-robin order, so the later grant wins in the register file.

Test Plan:
- Reset, then src_valid=3'b001, src_reg0=5, src_data0=0xDEADBEEF -> src_ready=3'b001 same cycle; next cycle RegWrite=1, Write_register=5, Write_data=0xDEADBEEF, grant_id=0, wb_count=1.
- src_valid=3'b111 held 6 cycles with distinct non-zero regs -> grants in order 0,1,2,0,1,2; RegWrite high 6 consecutive cycles; wb_count=6.
- src_valid=3'b101 with rr_ptr=1 -> source 2 granted first, then source 0 (wrap-around).
- Source 1 write to reg 0 with data 0x1234 -> src_ready[1]=1; next cycle RegWrite=0, wb_count unchanged; next grant starts searching at source 2.
- src_valid=3'b010 with wb_hold=1 for 3 cycles, then wb_hold=0 -> src_ready=0 and RegWrite=0 during hold; single write of source 1 one cycle after release.
- Reset pulse while src_valid=3'b111 and RegWrite=1 -> outputs 0 immediately (async); after release, source 0 is granted first.
